// File: rtl/glip_channel_mux.sv
// glip_channel_mux
//   Carries NUM_CH logical GLIP channels over one physical GLIP link.
//   TX: each channel has its own FIFO. A round-robin arbiter picks a
//   non-empty channel and sends a header word, followed by up to
//   MAX_BURST payload words from that channel.
//   RX: reads a header, then routes the payload words that follow it to
//   the addressed channel. Frames addressed to a channel that does not
//   exist are discarded, and err_bad_chan pulses once for each.
//
//   Header word: [WIDTH-1 -: CHW] = channel id, [LENW-1:0] = payload
//   count - 1. All other bits are zero.
//
// Ports
//   clk_logic       single clock, rising edge
//   rst             synchronous, active-high reset
//   ch_in_*         per-channel TX streams (data packed NUM_CH x WIDTH)
//   link_out_*      framed stream toward the link
//   link_in_*       framed stream from the link
//   ch_out_data     RX payload word, shared by all channels
//   ch_out_valid    one-hot RX valid, one bit per channel
//   ch_out_ready    per-channel RX ready
//   err_bad_chan    one-cycle pulse per discarded out-of-range header
module glip_channel_mux #(
   parameter int WIDTH     = 16,
   parameter int NUM_CH    = 4,
   parameter int DEPTH     = 8,
   parameter int MAX_BURST = 8
) (
   input  logic                    clk_logic,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] ch_in_data,
   input  logic [NUM_CH-1:0]       ch_in_valid,
   output logic [NUM_CH-1:0]       ch_in_ready,
   output logic [WIDTH-1:0]        link_out_data,
   output logic                    link_out_valid,
   input  logic                    link_out_ready,
   input  logic [WIDTH-1:0]        link_in_data,
   input  logic                    link_in_valid,
   output logic                    link_in_ready,
   output logic [WIDTH-1:0]        ch_out_data,
   output logic [NUM_CH-1:0]       ch_out_valid,
   input  logic [NUM_CH-1:0]       ch_out_ready,
   output logic                    err_bad_chan
);

   localparam int CHW  = $clog2(NUM_CH);
   localparam int LENW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int CNTW = LENW + 1;                       // holds 1..MAX_BURST
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW   = AW + 1;                         // holds 0..DEPTH

   typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_e;
   typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_DROP} rx_state_e;

   // ---------------------------------------------------------------
   // TX FIFOs
   // ---------------------------------------------------------------
   logic [WIDTH-1:0]          mem_q [NUM_CH][DEPTH];
   logic [NUM_CH-1:0][AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NUM_CH-1:0][FW-1:0] fill_q, fill_d;
   logic [NUM_CH-1:0]         push, pop;

   tx_state_e        tx_state_q, tx_state_d;
   logic [CHW-1:0]   tx_ch_q, tx_ch_d;
   logic [CNTW-1:0]  tx_cnt_q, tx_cnt_d;
   logic [CHW-1:0]   rr_q, rr_d;

   // NOTE: every signal written in an always_comb gets a default at the
   // top of the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_in_ready[i] = !rst && (fill_q[i] != FW'(DEPTH));
         push[i]        = ch_in_valid[i] && ch_in_ready[i];
         pop[i]         = (tx_state_q == TX_PAY) && link_out_ready && (tx_ch_q == CHW'(i));
         wr_ptr_d[i]    = push[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
         rd_ptr_d[i]    = pop[i]  ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
         case ({push[i], pop[i]})
            2'b10:   fill_d[i] = fill_q[i] + FW'(1);
            2'b01:   fill_d[i] = fill_q[i] - FW'(1);
            default: fill_d[i] = fill_q[i];
         endcase
      end
   end

   // NOTE: FIFO storage has no reset. Empty/full state is held entirely
   // in the pointers and fill counters, so clearing the array is unneeded.
   always_ff @(posedge clk_logic) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= ch_in_data[i*WIDTH +: WIDTH];
      end
   end

   // ---------------------------------------------------------------
   // Round-robin grant: first non-empty channel after rr_q, wrapping.
   // Scanning from the farthest channel to the nearest lets the nearest
   // one win by being assigned last.
   // ---------------------------------------------------------------
   logic           grant_vld;
   logic [CHW-1:0] grant_ch;
   logic [FW-1:0]  grant_fill;

   always_comb begin
      int idx;
      idx        = 0;
      grant_vld  = 1'b0;
      grant_ch   = '0;
      grant_fill = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = (int'(rr_q) + k) % NUM_CH;
         if (fill_q[CHW'(idx)] != '0) begin
            grant_vld  = 1'b1;
            grant_ch   = CHW'(idx);
            grant_fill = fill_q[CHW'(idx)];
         end
      end
   end

   // ---------------------------------------------------------------
   // TX framing FSM
   // ---------------------------------------------------------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_ch_d    = tx_ch_q;
      tx_cnt_d   = tx_cnt_q;
      rr_d       = rr_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (grant_vld) begin
               // Burst length is fixed at grant time. Later pushes to this
               // channel wait for its next turn.
               tx_ch_d    = grant_ch;
               rr_d       = grant_ch;
               tx_cnt_d   = (grant_fill >= FW'(MAX_BURST)) ? CNTW'(MAX_BURST) : CNTW'(grant_fill);
               tx_state_d = TX_HDR;
            end
         end
         TX_HDR: begin
            if (link_out_ready) tx_state_d = TX_PAY;
         end
         TX_PAY: begin
            if (link_out_ready) begin
               tx_cnt_d = tx_cnt_q - CNTW'(1);
               if (tx_cnt_q == CNTW'(1)) tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   logic [WIDTH-1:0] tx_hdr, tx_head;

   always_comb begin
      tx_hdr                 = '0;
      tx_hdr[WIDTH-1 -: CHW] = tx_ch_q;
      tx_hdr[LENW-1:0]       = LENW'(tx_cnt_q - CNTW'(1));
      tx_head                = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (tx_ch_q == CHW'(i)) tx_head = mem_q[i][rd_ptr_q[i]];
      end
   end

   // Decoded only from registered state, so both signals hold steady while
   // the link stalls, and valid never depends on ready.
   assign link_out_valid = !rst && (tx_state_q != TX_IDLE);
   assign link_out_data  = (tx_state_q == TX_PAY) ? tx_head : tx_hdr;

   // ---------------------------------------------------------------
   // RX parsing FSM
   // ---------------------------------------------------------------
   rx_state_e       rx_state_q, rx_state_d;
   logic [CHW-1:0]  rx_ch_q, rx_ch_d;
   logic [CNTW-1:0] rx_rem_q, rx_rem_d;
   logic            err_bad_chan_q, err_bad_chan_d;
   logic [CHW-1:0]  rx_hdr_ch;
   logic            rx_hdr_bad;
   logic            rx_sel_ready;

   assign ch_out_data  = link_in_data;
   assign err_bad_chan = err_bad_chan_q;

   always_comb begin
      rx_state_d     = rx_state_q;
      rx_ch_d        = rx_ch_q;
      rx_rem_d       = rx_rem_q;
      err_bad_chan_d = 1'b0;
      link_in_ready  = 1'b0;
      ch_out_valid   = '0;
      rx_hdr_ch      = link_in_data[WIDTH-1 -: CHW];
      rx_hdr_bad     = (int'(rx_hdr_ch) >= NUM_CH);
      rx_sel_ready   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rx_ch_q == CHW'(i)) rx_sel_ready = ch_out_ready[i];
      end

      case (rx_state_q)
         RX_HDR: begin
            link_in_ready = 1'b1;
            if (link_in_valid) begin
               rx_ch_d  = rx_hdr_ch;
               rx_rem_d = {1'b0, link_in_data[LENW-1:0]} + CNTW'(1);
               if (rx_hdr_bad) begin
                  err_bad_chan_d = 1'b1;
                  rx_state_d     = RX_DROP;
               end else begin
                  rx_state_d     = RX_PAY;
               end
            end
         end
         RX_PAY: begin
            // Payload is a straight pass-through. The addressed channel's
            // ready is what paces the link.
            for (int i = 0; i < NUM_CH; i++) begin
               if (rx_ch_q == CHW'(i)) ch_out_valid[i] = link_in_valid;
            end
            link_in_ready = rx_sel_ready;
            if (link_in_valid && rx_sel_ready) begin
               rx_rem_d = rx_rem_q - CNTW'(1);
               if (rx_rem_q == CNTW'(1)) rx_state_d = RX_HDR;
            end
         end
         RX_DROP: begin
            link_in_ready = 1'b1;
            if (link_in_valid) begin
               rx_rem_d = rx_rem_q - CNTW'(1);
               if (rx_rem_q == CNTW'(1)) rx_state_d = RX_HDR;
            end
         end
         default: rx_state_d = RX_HDR;
      endcase

      // No handshakes are offered while reset is held.
      if (rst) begin
         link_in_ready = 1'b0;
         ch_out_valid  = '0;
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples values from before the edge, whatever the block order.
   always_ff @(posedge clk_logic) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fill_q         <= '0;
         tx_state_q     <= TX_IDLE;
         tx_ch_q        <= '0;
         tx_cnt_q       <= '0;
         rr_q           <= CHW'(NUM_CH - 1);
         rx_state_q     <= RX_HDR;
         rx_ch_q        <= '0;
         rx_rem_q       <= '0;
         err_bad_chan_q <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         fill_q         <= fill_d;
         tx_state_q     <= tx_state_d;
         tx_ch_q        <= tx_ch_d;
         tx_cnt_q       <= tx_cnt_d;
         rr_q           <= rr_d;
         rx_state_q     <= rx_state_d;
         rx_ch_q        <= rx_ch_d;
         rx_rem_q       <= rx_rem_d;
         err_bad_chan_q <= err_bad_chan_d;
      end
   end

endmodule

// File: tb/tb_glip_channel_mux.sv
// Directed testbench for glip_channel_mux. The main instance uses the
// default parameters (4 channels). A second instance with NUM_CH = 3
// exercises headers that address a channel which does not exist.
module tb_glip_channel_mux;

   localparam int W = 16;
   localparam int N = 4;
   localparam int N3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [N*W-1:0] ch_in_data;
   logic [N-1:0]   ch_in_valid, ch_in_ready;
   logic [W-1:0]   link_out_data;
   logic           link_out_valid, link_out_ready;
   logic [W-1:0]   link_in_data;
   logic           link_in_valid, link_in_ready;
   logic [W-1:0]   ch_out_data;
   logic [N-1:0]   ch_out_valid, ch_out_ready;
   logic           err_bad_chan;

   logic [N3*W-1:0] ch_in_data3;
   logic [N3-1:0]   ch_in_valid3, ch_in_ready3;
   logic [W-1:0]    link_out_data3;
   logic            link_out_valid3, link_out_ready3;
   logic [W-1:0]    link_in_data3;
   logic            link_in_valid3, link_in_ready3;
   logic [W-1:0]    ch_out_data3;
   logic [N3-1:0]   ch_out_valid3, ch_out_ready3;
   logic            err_bad_chan3;

   glip_channel_mux u_dut (
      .clk_logic(clk), .rst(rst),
      .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
      .link_out_data(link_out_data), .link_out_valid(link_out_valid), .link_out_ready(link_out_ready),
      .link_in_data(link_in_data), .link_in_valid(link_in_valid), .link_in_ready(link_in_ready),
      .ch_out_data(ch_out_data), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
      .err_bad_chan(err_bad_chan)
   );

   glip_channel_mux #(.NUM_CH(N3)) u_dut3 (
      .clk_logic(clk), .rst(rst),
      .ch_in_data(ch_in_data3), .ch_in_valid(ch_in_valid3), .ch_in_ready(ch_in_ready3),
      .link_out_data(link_out_data3), .link_out_valid(link_out_valid3), .link_out_ready(link_out_ready3),
      .link_in_data(link_in_data3), .link_in_valid(link_in_valid3), .link_in_ready(link_in_ready3),
      .ch_out_data(ch_out_data3), .ch_out_valid(ch_out_valid3), .ch_out_ready(ch_out_ready3),
      .err_bad_chan(err_bad_chan3)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [W-1:0] mon_q[$];
   int           mon_edge[$];
   logic [W-1:0] exp_q[$];
   logic         stall_pend = 1'b0;
   logic [W-1:0] stall_data = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Link monitor: logs every link_out transfer together with the number
   // of the edge it lands on, and checks that stalled outputs hold still.
   always @(negedge clk) begin
      if (stall_pend && !rst) begin
         check("stall_valid", link_out_valid, 1);
         check("stall_data", link_out_data, stall_data);
      end
      stall_pend = link_out_valid && !link_out_ready && !rst;
      stall_data = link_out_data;
      if (link_out_valid && link_out_ready) begin
         mon_q.push_back(link_out_data);
         mon_edge.push_back(cyc + 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input int ch, input logic [W-1:0] d);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      ch_in_data[ch*W +: W] = d;
      ch_in_valid[ch]       = 1'b1;
      while (!acc && n < 100) begin
         acc = ch_in_ready[ch];
         tick();
         n++;
      end
      ch_in_valid[ch] = 1'b0;
      check($sformatf("push_accept_ch%0d", ch), acc, 1);
   endtask

   task automatic check_stream(input string tag);
      int n;
      n = 0;
      while (mon_q.size() < exp_q.size() && n < 400) begin
         tick();
         n++;
      end
      repeat (6) tick();
      check({tag, "_len"}, mon_q.size(), exp_q.size());
      foreach (exp_q[i])
         check($sformatf("%s_w%0d", tag, i),
               (i < mon_q.size()) ? 32'(mon_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
      mon_q.delete();
      mon_edge.delete();
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t;
      int n;
      rst = 1'b1;
      ch_in_data = '0;  ch_in_valid = '0;  link_out_ready = 1'b1;
      link_in_data = '0; link_in_valid = 1'b0; ch_out_ready = '1;
      ch_in_data3 = '0; ch_in_valid3 = '0; link_out_ready3 = 1'b1;
      link_in_data3 = '0; link_in_valid3 = 1'b0; ch_out_ready3 = '0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ch_in_ready", ch_in_ready, 0);
      check("rst_link_out_valid", link_out_valid, 0);
      check("rst_link_in_ready", link_in_ready, 0);
      check("rst_ch_out_valid", ch_out_valid, 0);
      check("rst_err", err_bad_chan, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ch_in_ready", ch_in_ready, 4'hF);
      check("post_rst_link_in_ready", link_in_ready, 1);
      tick();

      // ---- single word on ch1: header 4000 at t+2, payload at t+3 ----
      push_word(1, 16'hBEEF);
      t = cyc;
      n = 0;
      while (mon_q.size() < 2 && n < 20) begin tick(); n++; end
      check("lat_hdr_edge", (mon_edge.size() >= 1) ? mon_edge[0] : -1, t + 2);
      check("lat_pay_edge", (mon_edge.size() >= 2) ? mon_edge[1] : -1, t + 3);
      exp_q = '{16'h4000, 16'hBEEF};
      check_stream("single");

      // ---- burst cap: ch1 holds the link while ch0 fills up ----
      link_out_ready = 1'b0;
      push_word(1, 16'h1111);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("cap_ready_at_7", ch_in_ready[0], 1);
         push_word(0, 16'(i));
      end
      check("cap_ready_at_8", ch_in_ready[0], 0);
      link_out_ready = 1'b1;
      push_word(0, 16'd8);
      push_word(0, 16'd9);
      exp_q = '{16'h4000, 16'h1111, 16'h0007};
      for (int i = 0; i < 8; i++) exp_q.push_back(16'(i));
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'd8);
      exp_q.push_back(16'd9);
      check_stream("cap");

      // ---- round robin: after ch3 the order is ch0, ch2, ch3 ----
      link_out_ready = 1'b0;
      push_word(3, 16'h3333);
      push_word(0, 16'hA0A0); push_word(0, 16'hA1A1);
      push_word(2, 16'hC0C0); push_word(2, 16'hC1C1);
      push_word(3, 16'hD0D0); push_word(3, 16'hD1D1);
      link_out_ready = 1'b1;
      n = 0;
      while (mon_q.size() < 3 && n < 100) begin tick(); n++; end
      push_word(0, 16'hA2A2);
      exp_q = '{16'hC000, 16'h3333, 16'h0001, 16'hA0A0, 16'hA1A1,
                16'h8001, 16'hC0C0, 16'hC1C1, 16'hC001, 16'hD0D0, 16'hD1D1,
                16'h0000, 16'hA2A2};
      check_stream("rr");

      // ---- TX backpressure: random link_out_ready during a 4-word burst ----
      link_out_ready = 1'b0;
      push_word(1, 16'h1111);
      for (int i = 0; i < 4; i++) push_word(2, 16'h2000 + 16'(i));
      n = 0;
      while (mon_q.size() < 7 && n < 400) begin
         link_out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      link_out_ready = 1'b1;
      exp_q = '{16'h4000, 16'h1111, 16'h8003, 16'h2000, 16'h2001, 16'h2002, 16'h2003};
      check_stream("bp");

      // ---- RX routing to ch2 with a stall ----
      ch_out_ready  = 4'b1011;
      link_in_valid = 1'b1;
      link_in_data  = 16'h8002;
      @(negedge clk);
      check("rx_hdr_ready", link_in_ready, 1);
      check("rx_hdr_valid", ch_out_valid, 0);
      tick();
      link_in_data = 16'h0A0A;
      @(negedge clk);
      check("rx_a_valid", ch_out_valid, 4'b0100);
      check("rx_a_stall_ready", link_in_ready, 0);
      check("rx_a_data", ch_out_data, 16'h0A0A);
      tick();
      @(negedge clk);
      check("rx_a_hold_valid", ch_out_valid, 4'b0100);
      check("rx_a_hold_ready", link_in_ready, 0);
      tick();
      ch_out_ready = 4'b0100;
      @(negedge clk);
      check("rx_a_go_ready", link_in_ready, 1);
      tick();
      link_in_data = 16'h0B0B;
      @(negedge clk);
      check("rx_b_valid", ch_out_valid, 4'b0100);
      check("rx_b_data", ch_out_data, 16'h0B0B);
      tick();
      link_in_data = 16'h0C0C;
      @(negedge clk);
      check("rx_c_valid", ch_out_valid, 4'b0100);
      check("rx_c_ready", link_in_ready, 1);
      tick();
      link_in_valid = 1'b0;
      ch_out_ready  = '1;
      @(negedge clk);
      check("rx_done_valid", ch_out_valid, 0);
      check("rx_done_ready", link_in_ready, 1);
      tick();

      // ---- bad channel on the 3-channel instance ----
      link_in_valid3 = 1'b1;
      link_in_data3  = 16'hC001;
      @(negedge clk);
      check("bad_hdr_ready", link_in_ready3, 1);
      check("bad_err_before", err_bad_chan3, 0);
      tick();
      link_in_data3 = 16'h1234;
      @(negedge clk);
      check("bad_err_pulse", err_bad_chan3, 1);
      check("bad_drop1_valid", ch_out_valid3, 0);
      check("bad_drop1_ready", link_in_ready3, 1);
      tick();
      link_in_data3 = 16'h5678;
      @(negedge clk);
      check("bad_err_cleared", err_bad_chan3, 0);
      check("bad_drop2_valid", ch_out_valid3, 0);
      check("bad_drop2_ready", link_in_ready3, 1);
      tick();
      link_in_data3 = 16'h4000;
      @(negedge clk);
      check("bad_next_hdr_ready", link_in_ready3, 1);
      check("bad_next_hdr_valid", ch_out_valid3, 0);
      tick();
      link_in_data3 = 16'h9ABC;
      ch_out_ready3 = 3'b010;
      @(negedge clk);
      check("bad_next_pay_valid", ch_out_valid3, 3'b010);
      check("bad_next_pay_data", ch_out_data3, 16'h9ABC);
      tick();
      link_in_valid3 = 1'b0;
      @(negedge clk);
      check("bad_end_valid", ch_out_valid3, 0);
      check("bad_end_err", err_bad_chan3, 0);
      tick();

      // ---- reset in the middle of a burst ----
      link_out_ready = 1'b0;
      push_word(0, 16'hAA00);
      push_word(0, 16'hAA01);
      push_word(0, 16'hAA02);
      link_out_ready = 1'b1;
      tick();
      link_out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", link_out_valid, 0);
      check("mid_rst_ch_in_ready", ch_in_ready, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_valid", link_out_valid, 0);
      check("after_rst_ch_in_ready", ch_in_ready, 4'hF);
      tick();
      mon_q.delete();
      mon_edge.delete();
      link_out_ready = 1'b1;
      repeat (5) tick();
      check("after_rst_no_stale", mon_q.size(), 0);
      ch_in_data[0*W +: W] = 16'hB000;
      ch_in_data[1*W +: W] = 16'hB001;
      ch_in_valid = 4'b0011;
      tick();
      ch_in_valid = '0;
      exp_q = '{16'h0000, 16'hB000, 16'h4000, 16'hB001};
      check_stream("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/glip_channel_mux.md
Name: glip_channel_mux

Overview:
- Multiplexes NUM_CH logical GLIP channels onto one physical GLIP channel (host link), and demultiplexes the opposite direction.
- Turns the single-stream logic-side bridge into a multi-channel link. Sits between the link-side FIFO interface (TCP/UART/USB backend) and several debug/data endpoints.
- TX side: per-channel input FIFOs, round-robin arbitration, and a header-framed burst stream.
- RX side: parses headers and routes payload words to the addressed channel.

Parameters:
- WIDTH, 16: link and channel word width in bits. WIDTH >= CHW+LENW.
- NUM_CH, 4: number of logical channels, 2..16.
- DEPTH, 8: per-channel TX FIFO depth in words. Power of two.
- MAX_BURST, 8: maximum payload words per header. Power of two, <= DEPTH.
- Derived: CHW = $clog2(NUM_CH); LENW = $clog2(MAX_BURST), minimum 1.

Ports:
- clk_logic  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- ch_in_data  in  NUM_CH*WIDTH  Per-channel TX data; channel i occupies bits [i*WIDTH +: WIDTH].
- ch_in_valid  in  NUM_CH  Per-channel TX valid.
- ch_in_ready  out  NUM_CH  Per-channel TX ready (FIFO not full).
- link_out_data  out  WIDTH  Framed stream to the link.
- link_out_valid  out  1  Framed stream valid.
- link_out_ready  in  1  Link backpressure.
- link_in_data  in  WIDTH  Framed stream from the link.
- link_in_valid  in  1  Framed stream valid.
- link_in_ready  out  1  Ready toward the link.
- ch_out_data  out  WIDTH  RX payload word, shared by all channels.
- ch_out_valid  out  NUM_CH  One-hot RX valid per channel.
- ch_out_ready  in  NUM_CH  Per-channel RX ready.
- err_bad_chan  out  1  One-cycle pulse per discarded header with channel >= NUM_CH.

Behaviour:
- Handshake on all interfaces: transfer when valid & ready on a rising edge. Valid must not depend combinationally on ready.
- Header word format:
  - bits [WIDTH-1 -: CHW] = channel id.
  - bits [LENW-1:0] = payload count - 1.
  - All other bits = 0.
- Reset state: every FIFO empty, fill = 0; TX FSM in IDLE; RX FSM in RX_HDR; round-robin pointer = NUM_CH-1, so channel 0 has first priority. err_bad_chan = 0.
- Outputs during reset: ch_in_ready = 0, link_out_valid = 0, ch_out_valid = 0, link_in_ready = 0. ch_in_ready is 1 from the first cycle after reset deasserts. Reset mid-burst abandons the burst; no partial frame is resumed.
- TX FIFOs:
  - ch_in_ready[i] = (fill_i != DEPTH).
  - Simultaneous push and pop leaves fill unchanged.
  - Data pushed at edge t is counted in fill from t+1.
- TX FSM, IDLE:
  - If any fill_i != 0, grant the first nonempty channel after the pointer (wrapping).
  - Latch cnt = min(fill_i, MAX_BURST) and set pointer = i.
  - Go to TX_HDR. link_out_valid = 0 in IDLE.
- TX FSM, TX_HDR:
  - link_out_valid = 1, link_out_data = header.
  - On handshake, go to TX_PAY.
- TX FSM, TX_PAY:
  - link_out_valid = 1, link_out_data = head of FIFO i.
  - Each handshake pops FIFO i and decrements cnt. Handshake with cnt == 1 returns to IDLE.
  - Words pushed to channel i during a burst do not extend cnt.
- TX latency: a word pushed into an empty system at edge t gives header valid in cycle t+2 and payload in cycle t+3 (with link_out_ready held high).
- TX output stability: while link_out_ready = 0, link_out_valid and link_out_data stay stable.
- RX FSM, RX_HDR:
  - link_in_ready = 1.
  - On handshake, latch ch = header[WIDTH-1 -: CHW] and rem = header[LENW-1:0] + 1.
  - If ch >= NUM_CH, pulse err_bad_chan next cycle and go to RX_DROP. Otherwise go to RX_PAY.
- RX FSM, RX_PAY:
  - ch_out_data = link_in_data (combinational pass-through).
  - ch_out_valid[ch] = link_in_valid; link_in_ready = ch_out_ready[ch].
  - Each transfer decrements rem. The transfer with rem == 1 returns to RX_HDR.
- RX FSM, RX_DROP: link_in_ready = 1; consume and discard rem words, then return to RX_HDR.
- Concurrency: TX and RX paths are fully independent, and a single-cycle bubble between bursts is permitted.

Test Plan:
- Single word: ch1 pushes 16'hBEEF at edge t -> link_out emits header 16'h4000 at t+2, then 16'hBEEF; exactly 2 link words.
- Burst cap: ch0 pushes 10 words 0..9 back-to-back -> header 16'h0007 + words 0..7, then header 16'h0001 + words 8,9. ch_in_ready[0] drops when 8 words are unpopped.
- Round-robin: ch0, ch2, ch3 each preloaded with 2 words before the first grant -> bursts in order ch0, ch2, ch3. Next ch0 data waits until after ch3.
- TX backpressure: link_out_ready toggled randomly 50% during a 4-word burst -> data stable while stalled, no loss or duplication, order preserved.
- RX routing: link_in sends 16'h8002, A, B, C -> ch_out_valid = 4'b0100 for 3 words. Holding ch_out_ready[2] = 0 holds link_in_ready = 0.
- Bad channel and reset: with NUM_CH = 3, header 16'hC001 plus 2 words -> words dropped, one err_bad_chan pulse. rst asserted mid-TX-burst -> next cycle link_out_valid = 0, FIFOs empty, channel 0 has first priority.
